// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: UART transmitter with a small transmit FIFO.
// Frame format is fixed at elaboration: start bit, DATA_BITS data bits LSB
// first, optional odd/even parity bit, then STOP_BITS stop bits. One bit is
// emitted per baud_clk edge. A new frame starts straight after the last stop
// bit when a word is waiting, so there is no idle gap between queued words.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | line high, waiting for the FIFO to hold a word
// START  | start bit (0) on the line; frame register holds the word
// DATA   | data bit frame[bit_idx] on the line
// PARITY | parity bit on the line
// STOP   | stop bit on the line; stop_cnt counts down the remaining ones

module uart_tx_cfg #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        baud_clk,
    input  logic                        reset,
    input  logic [DATA_BITS-1:0]        data_in,
    input  logic                        valid,
    output logic                        ready,
    output logic                        tx,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int IW = $clog2(DATA_BITS);

    localparam logic [CW-1:0] FIFO_FULL = CW'(FIFO_DEPTH);
    localparam logic [IW-1:0] LAST_IDX  = IW'(DATA_BITS - 1);
    // Stop-bit timer load: counts down to zero on the final stop cycle.
    localparam logic          STOP_LOAD = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    // ------------------------------------------------------------------
    // Transmit FIFO
    // ------------------------------------------------------------------
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [CW-1:0]        count;
    logic                 push;
    logic                 pop;
    logic                 empty;
    logic [DATA_BITS-1:0] head;

    assign ready      = (count != FIFO_FULL);
    assign push       = valid && ready;
    assign empty      = (count == '0);
    assign head       = mem[rd_ptr];
    assign fifo_count = count;

    // Storage array: written on accepted pushes only, never reset.
    always_ff @(posedge baud_clk) begin
        if (push) begin
            mem[wr_ptr] <= data_in;
        end
    end

    // Pointers wrap naturally because FIFO_DEPTH is a power of two; the
    // separate occupancy count keeps full and empty unambiguous.
    always_ff @(posedge baud_clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Frame sequencer
    // ------------------------------------------------------------------
    state_t               state;
    state_t               state_nx;
    logic                 tx_q;
    logic                 tx_nx;
    logic [IW-1:0]        bit_idx;
    logic [IW-1:0]        bit_idx_nx;
    logic [IW-1:0]        bit_idx_inc;
    logic                 stop_cnt;
    logic                 stop_cnt_nx;
    logic [DATA_BITS-1:0] frame;
    logic [DATA_BITS-1:0] frame_nx;
    logic                 par_bit;

    assign bit_idx_inc = bit_idx + IW'(1);
    // Even parity is the XOR of the data bits; odd parity is its inverse.
    assign par_bit     = (PARITY == 1) ? ~(^frame) : (^frame);

    assign tx   = tx_q;
    assign busy = (state != S_IDLE);

    // Sequencer registers; reset forces an idle, high line immediately.
    always_ff @(posedge baud_clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            tx_q     <= 1'b1;
            bit_idx  <= '0;
            stop_cnt <= 1'b0;
            frame    <= '0;
        end else begin
            state    <= state_nx;
            tx_q     <= tx_nx;
            bit_idx  <= bit_idx_nx;
            stop_cnt <= stop_cnt_nx;
            frame    <= frame_nx;
        end
    end

    // Next state and next line value; tx_nx is the bit of the state entered.
    always_comb begin
        state_nx    = state;
        tx_nx       = tx_q;
        bit_idx_nx  = bit_idx;
        stop_cnt_nx = stop_cnt;
        frame_nx    = frame;
        pop         = 1'b0;

        case (state)
            S_IDLE: begin
                tx_nx = 1'b1;
                if (!empty) begin
                    pop      = 1'b1;
                    frame_nx = head;
                    tx_nx    = 1'b0;
                    state_nx = S_START;
                end
            end

            S_START: begin
                tx_nx      = frame[0];
                bit_idx_nx = '0;
                state_nx   = S_DATA;
            end

            S_DATA: begin
                if (bit_idx == LAST_IDX) begin
                    if (PARITY != 0) begin
                        tx_nx    = par_bit;
                        state_nx = S_PARITY;
                    end else begin
                        tx_nx       = 1'b1;
                        stop_cnt_nx = STOP_LOAD;
                        state_nx    = S_STOP;
                    end
                end else begin
                    bit_idx_nx = bit_idx_inc;
                    tx_nx      = frame[bit_idx_inc];
                end
            end

            S_PARITY: begin
                tx_nx       = 1'b1;
                stop_cnt_nx = STOP_LOAD;
                state_nx    = S_STOP;
            end

            S_STOP: begin
                tx_nx = 1'b1;
                if (stop_cnt == 1'b0) begin
                    // Last stop cycle: chain straight into the next frame.
                    if (!empty) begin
                        pop      = 1'b1;
                        frame_nx = head;
                        tx_nx    = 1'b0;
                        state_nx = S_START;
                    end else begin
                        state_nx = S_IDLE;
                    end
                end else begin
                    stop_cnt_nx = stop_cnt - 1'b1;
                end
            end

            default: begin
                state_nx    = S_IDLE;
                tx_nx       = 1'b1;
                bit_idx_nx  = '0;
                stop_cnt_nx = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb_uart_tx_cfg: five differently configured transmitters share one stimulus
// stream. A word-queue / bit-schedule model predicts every output each cycle;
// hand-derived line traces pin the model on the key frames.

module tb_uart_tx_cfg;

    localparam int N     = 5;
    localparam int DEPTH = 4;
    localparam int DB  [N] = '{8, 8, 8, 8, 5};
    localparam int PAR [N] = '{0, 2, 1, 0, 0};
    localparam int SB  [N] = '{1, 1, 1, 2, 1};

    logic       clk   = 1'b0;
    logic       rst   = 1'b0;
    logic       valid = 1'b0;
    logic [8:0] din   = '0;
    logic       chk_en = 1'b0;

    logic       tx_v    [N];
    logic       busy_v  [N];
    logic       ready_v [N];
    logic [2:0] cnt_v   [N];

    int checks = 0;
    int errors = 0;

    logic [31:0] trp [N];
    int          nb  [N];
    int          maxc;

    always #5 clk = ~clk;

    uart_tx_cfg #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u0 (
        .baud_clk(clk), .reset(rst), .data_in(din[7:0]), .valid(valid),
        .ready(ready_v[0]), .tx(tx_v[0]), .busy(busy_v[0]), .fifo_count(cnt_v[0]));
    uart_tx_cfg #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u1 (
        .baud_clk(clk), .reset(rst), .data_in(din[7:0]), .valid(valid),
        .ready(ready_v[1]), .tx(tx_v[1]), .busy(busy_v[1]), .fifo_count(cnt_v[1]));
    uart_tx_cfg #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) u2 (
        .baud_clk(clk), .reset(rst), .data_in(din[7:0]), .valid(valid),
        .ready(ready_v[2]), .tx(tx_v[2]), .busy(busy_v[2]), .fifo_count(cnt_v[2]));
    uart_tx_cfg #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(4)) u3 (
        .baud_clk(clk), .reset(rst), .data_in(din[7:0]), .valid(valid),
        .ready(ready_v[3]), .tx(tx_v[3]), .busy(busy_v[3]), .fifo_count(cnt_v[3]));
    uart_tx_cfg #(.DATA_BITS(5), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u4 (
        .baud_clk(clk), .reset(rst), .data_in(din[4:0]), .valid(valid),
        .ready(ready_v[4]), .tx(tx_v[4]), .busy(busy_v[4]), .fifo_count(cnt_v[4]));

    // ------------------------------------------------------------------
    // Model: a queue of accepted words plus a schedule of line bits still to
    // be sent. When the schedule runs dry and a word was waiting before the
    // edge, the whole frame is laid out as an integer bit pattern.
    // ------------------------------------------------------------------
    logic [8:0] mq [N][32];
    logic [4:0] mh [N];
    logic [4:0] mt [N];
    int         msched [N];
    int         mlen [N];
    logic       m_tx [N];
    logic       m_busy [N];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                mh[i]     = '0;
                mt[i]     = '0;
                msched[i] = 0;
                mlen[i]   = 0;
                m_tx[i]   = 1'b1;
                m_busy[i] = 1'b0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                logic [4:0] pre;
                int wm;
                int pb;
                int pv;
                pre = mt[i] - mh[i];
                if (mlen[i] == 0 && pre != 5'd0) begin
                    wm    = int'(mq[i][mh[i]]) & ((1 << DB[i]) - 1);
                    mh[i] = mh[i] + 5'd1;
                    pb    = (PAR[i] != 0) ? 1 : 0;
                    pv    = $countones(wm) % 2;
                    if (PAR[i] == 1) pv = 1 - pv;
                    if (pb == 0) pv = 0;
                    msched[i] = (wm << 1) | (pv << (1 + DB[i]))
                              | (((1 << SB[i]) - 1) << (1 + DB[i] + pb));
                    mlen[i]   = 1 + DB[i] + pb + SB[i];
                end
                if (mlen[i] > 0) begin
                    m_tx[i]   = msched[i][0];
                    msched[i] = msched[i] >> 1;
                    mlen[i]   = mlen[i] - 1;
                    m_busy[i] = 1'b1;
                end else begin
                    m_tx[i]   = 1'b1;
                    m_busy[i] = 1'b0;
                end
                if (valid && pre != 5'd4) begin
                    mq[i][mt[i]] = din;
                    mt[i]        = mt[i] + 5'd1;
                end
            end
        end
    end

    task automatic chk(input string name, input int inst,
                       input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s inst%0d t=%0t got %0h want %0h", name, inst, $time, got, want);
        end
    endtask

    // Advance to the next falling edge and compare every instance to the model.
    task automatic tick();
        logic [4:0] c;
        @(negedge clk);
        if (chk_en) begin
            for (int i = 0; i < N; i++) begin
                c = mt[i] - mh[i];
                chk("tx",    i, 32'(tx_v[i]),    32'(m_tx[i]));
                chk("busy",  i, 32'(busy_v[i]),  32'(m_busy[i]));
                chk("count", i, 32'(cnt_v[i]),   32'(c));
                chk("ready", i, 32'(ready_v[i]), 32'(c != 5'd4));
            end
        end
    endtask

    // Sample the line and busy of every instance for n cycles, starting now.
    task automatic record(input int n);
        for (int i = 0; i < N; i++) begin
            trp[i] = '0;
            nb[i]  = 0;
        end
        for (int j = 0; j < n; j++) begin
            for (int i = 0; i < N; i++) begin
                trp[i] = trp[i] | (32'(tx_v[i]) << j);
                if (busy_v[i]) nb[i] = nb[i] + 1;
            end
            tick();
        end
    endtask

    function automatic logic all_idle();
        logic r;
        r = 1'b1;
        for (int i = 0; i < N; i++) begin
            if (busy_v[i] !== 1'b0 || cnt_v[i] !== 3'd0) r = 1'b0;
        end
        return r;
    endfunction

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (n < budget && !all_idle()) begin
            tick();
            n++;
        end
        chk("idle_reached", 0, 32'(all_idle()), 32'd1);
    endtask

    task automatic check_reset_outputs(input string name);
        for (int i = 0; i < N; i++) begin
            chk({name, "_tx"},    i, 32'(tx_v[i]),    32'd1);
            chk({name, "_busy"},  i, 32'(busy_v[i]),  32'd0);
            chk({name, "_count"}, i, 32'(cnt_v[i]),   32'd0);
            chk({name, "_ready"}, i, 32'(ready_v[i]), 32'd1);
        end
    endtask

    initial begin
        // Asynchronous reset takes effect before any clock edge.
        #1 rst = 1'b1;
        #1;
        check_reset_outputs("rst_init");
        repeat (2) @(negedge clk);
        rst    = 1'b0;
        chk_en = 1'b1;
        repeat (2) tick();

        // 0x55 on 8N1: start, 1,0,1,0,1,0,1,0, stop, then idle.
        valid = 1'b1; din = 9'h055;
        tick();
        valid = 1'b0; din = 9'h1AA;
        tick();
        record(11);
        chk("frame_55",      0, trp[0],     32'b11010101010);
        chk("frame_55_busy", 0, 32'(nb[0]), 32'd10);
        wait_idle(40);

        // 0x07: three ones, so even parity bit is 1 and odd parity bit is 0.
        valid = 1'b1; din = 9'h007;
        tick();
        valid = 1'b0; din = 9'h0F0;
        tick();
        record(13);
        chk("frame_07_even", 1, trp[1],     32'b1111000001110);
        chk("par_even",      1, 32'(trp[1][9]), 32'd1);
        chk("par_odd",       2, 32'(trp[2][9]), 32'd0);
        chk("len_even",      1, 32'(nb[1]), 32'd11);
        chk("len_odd",       2, 32'(nb[2]), 32'd11);
        chk("len_8n1",       0, 32'(nb[0]), 32'd10);
        chk("len_5bit",      4, 32'(nb[4]), 32'd7);
        wait_idle(40);

        // 0xA3 then 0x3C on consecutive edges with two stop bits: no gap.
        valid = 1'b1; din = 9'h0A3;
        tick();
        din = 9'h03C;
        tick();
        valid = 1'b0; din = 9'h155;
        record(25);
        chk("stop2_pair", 3, trp[3], {7'b0, 25'b1111100111100011101000110});
        chk("stop2_busy", 3, 32'(nb[3]), 32'd22);
        chk("8n1_pair_busy", 0, 32'(nb[0]), 32'd20);
        wait_idle(40);

        // Six offers back to back: one popped, four queued, sixth dropped.
        valid = 1'b1;
        for (int j = 0; j < 6; j++) begin
            din = 9'((j + 1) * 17);
            tick();
            if (j == 4) begin
                chk("full_count", 0, 32'(cnt_v[0]),   32'd4);
                chk("full_ready", 0, 32'(ready_v[0]), 32'd0);
            end
            if (j == 5) chk("drop_count", 0, 32'(cnt_v[0]), 32'd4);
        end
        valid = 1'b0;
        wait_idle(90);

        // Reset during data bit 3 with two words queued.
        valid = 1'b1; din = 9'h05A;
        tick();
        din = 9'h0C3;
        tick();
        din = 9'h096;
        tick();
        valid = 1'b0; din = 9'h1FF;
        repeat (3) tick();
        chk("mid_busy",  0, 32'(busy_v[0]), 32'd1);
        chk("mid_count", 0, 32'(cnt_v[0]),  32'd2);
        chk("mid_bit3",  0, 32'(tx_v[0]),   32'd1);
        #1 rst = 1'b1;
        #1;
        check_reset_outputs("rst_async");
        tick();
        tick();
        rst = 1'b0;
        record(6);
        chk("post_rst_line", 0, trp[0],     32'h3F);
        chk("post_rst_busy", 0, 32'(nb[0]), 32'd0);
        valid = 1'b1; din = 9'h00F;
        tick();
        valid = 1'b0; din = 9'h0E1;
        wait_idle(40);

        // Continuous offers: the 5-bit instance wraps its pointers several times.
        maxc  = 0;
        valid = 1'b1;
        for (int j = 0; j < 14; j++) begin
            din = 9'((j * 37 + 11) % 512);
            tick();
            if (int'(cnt_v[4]) > maxc) maxc = int'(cnt_v[4]);
        end
        valid = 1'b0;
        chk("wrap_max_count", 4, 32'(maxc), 32'd4);
        wait_idle(120);

        // Sparse random traffic.
        for (int j = 0; j < 300; j++) begin
            valid = ($urandom_range(0, 2) == 0);
            din   = 9'($urandom);
            tick();
        end
        valid = 1'b0;
        wait_idle(150);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_cfg.md
UART_TX_CFG -- requirements
Module: uart_tx_cfg

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8: data bits per frame; legal range 5..9.
REQ-002 SHALL have parameter PARITY, default 0: 0 = none, 1 = odd, 2 = even.
REQ-003 SHALL have parameter STOP_BITS, default 1: stop bits per frame; legal values 1 or 2.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4: transmit FIFO entries; power of 2, range 2..16.
REQ-005 SHALL have port baud_clk, input, 1 bit: clock, one edge per bit period.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port data_in, input, DATA_BITS bits: word to transmit.
REQ-008 SHALL have port valid, input, 1 bit: data_in is offered this cycle.
REQ-009 SHALL have port ready, output, 1 bit: FIFO can accept a word.
REQ-010 SHALL have port tx, output, 1 bit: serial line, idle high, registered.
REQ-011 SHALL have port busy, output, 1 bit: a frame is in progress.
REQ-012 SHALL have port fifo_count, output, $clog2(FIFO_DEPTH)+1 bits: number of words queued, excluding the word currently being sent.

Function
REQ-013 SHALL assign ready = (fifo_count != FIFO_DEPTH), combinationally.
REQ-014 SHALL push data_in into the FIFO on a baud_clk edge when valid && ready; when !ready, valid SHALL be ignored and the word dropped.
REQ-015 SHALL base pop eligibility on FIFO state before the edge, so a word pushed at edge k is popped no earlier than edge k+1.
REQ-016 SHALL allow a push and a pop on the same edge; fifo_count SHALL then remain unchanged and the words SHALL remain in order.
REQ-017 SHALL implement FIFO pointers that wrap modulo FIFO_DEPTH and SHALL keep fifo_count exact across wrap-around.
REQ-018 SHALL implement states IDLE, START, DATA, PARITY, STOP, with state and tx updated on the same edge; tx reflects the current state's bit.
REQ-019 IDLE: tx=1; if the FIFO is non-empty, SHALL pop the head into a frame register, set tx<=0 and go to START.
REQ-020 START: SHALL set tx<=frame[0], set bit index=0 and go to DATA.
REQ-021 DATA: SHALL increment the index and drive frame[index] LSB first; after bit DATA_BITS-1 has been held one cycle, SHALL go to PARITY if PARITY!=0, else to STOP with tx<=1.
REQ-022 PARITY: SHALL drive even parity = XOR of the data bits and odd parity = its inverse, held one cycle, then go to STOP with tx<=1.
REQ-023 STOP: SHALL hold tx=1 for STOP_BITS cycles; on the final stop cycle, if the FIFO is non-empty SHALL pop, set tx<=0 and go to START (no idle gap), else go to IDLE.
REQ-024 SHALL make the frame length exactly 1+DATA_BITS+(PARITY!=0)+STOP_BITS baud_clk cycles.
REQ-025 SHALL assert busy whenever state != IDLE, derived from registered state.
REQ-026 SHALL make changes to data_in after acceptance have no effect on queued or in-flight words.
REQ-027 SHALL make illegal states recover to IDLE with tx=1 on the next edge.

Reset
REQ-028 On reset assertion, SHALL immediately, without waiting for a clock: state=IDLE, tx=1, busy=0, fifo_count=0, FIFO pointers=0, bit index=0; ready SHALL therefore be 1.
REQ-029 A reset mid-frame SHALL abort the frame and discard all queued words; no partial-frame bits SHALL appear after reset deasserts.
REQ-030 After reset deasserts, the first accepted word SHALL start its frame as per REQ-019.

Verification
REQ-031 Defaults: push 0x55 at edge k with idle -> tx over edges k+1..k+10 = 0,1,0,1,0,1,0,1,0,1, then 1 and busy=0 from edge k+11; busy=1 for exactly 10 cycles.
REQ-032 PARITY=2: send 0x07 -> parity bit=1; PARITY=1: send 0x07 -> parity bit=0; frame length = 11 cycles.
REQ-033 STOP_BITS=2: push 0xA3 and 0x3C on consecutive edges -> two contiguous 11-cycle frames, stop high for 2 cycles, second start bit immediately follows, no idle cycle.
REQ-034 Defaults: push 5 words back-to-back with valid=1 -> first is popped, 4 queued, fifo_count=4, ready=0, 6th offer dropped; all 5 accepted words are transmitted in order.
REQ-035 Assert reset during data bit 3 of a frame with 2 words queued -> tx=1, busy=0, fifo_count=0 asynchronously; tx stays 1 after release until a new push.
REQ-036 DATA_BITS=5: send 0x1F with 10+ pushes wrapping FIFO pointers -> 7-cycle frames, order preserved, fifo_count never exceeds 4.
